// File: rtl/spi_file_loader.sv
// spi_file_loader
//   Receives OSD file-transfer commands over the MiST SPI link (0x53 start/end,
//   0x54 data, 0x55 index), packs 0x54 payload bytes into DW-wide little-endian
//   words, queues the words in a small FIFO and writes them to external RAM
//   over a wr/ack handshake. Everything runs on clk; the SPI pins are
//   oversampled through 2-FF synchronisers.
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   sck, ss, sdi        SPI from the I/O controller (mode 0, MSB first)
//   downloading         start command seen, FIFO not yet drained after end
//   index               last file index received
//   wr, ack, a, d       RAM write port; wr held until ack, a/d stable meanwhile
//   size                payload byte count of the current or last transfer
//   overflow            sticky: a word was dropped on a full FIFO
//   crc                 payload CRC-16/CCITT
// Configuration
//   DATA_IO_CRC_EN      defined: running CRC on crc; undefined: crc = 16'h0000
module spi_file_loader #(
    parameter int unsigned   DW         = 16,
    parameter int unsigned   AW         = 25,
    parameter int unsigned   FIFO_DEPTH = 4,
    parameter logic [AW-1:0] BASE0      = AW'(25'h0E0000),
    parameter logic [AW-1:0] BASE1      = AW'(25'h100000),
    parameter logic [AW-1:0] BASE_DEF   = AW'(25'h120000)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sck,
    input  logic          ss,
    input  logic          sdi,
    output logic          downloading,
    output logic [4:0]    index,
    output logic          wr,
    input  logic          ack,
    output logic [AW-1:0] a,
    output logic [DW-1:0] d,
    output logic [AW-1:0] size,
    output logic          overflow,
    output logic [15:0]   crc
);

    localparam int unsigned    NL       = DW / 8;
    localparam int unsigned    LBW      = (NL > 1) ? $clog2(NL) : 1;
    localparam int unsigned    PW       = $clog2(FIFO_DEPTH);
    localparam logic [LBW-1:0] LANE_TOP = LBW'(NL - 1);
    localparam logic [AW-1:0]  LANE_MSK = AW'(NL - 1);
    localparam logic [PW:0]    FULL_CNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [0:0]     ST_IDLE  = 1'b0;
    localparam logic [0:0]     ST_WRITE = 1'b1;

    // ---------------- SPI front end ----------------
    logic [1:0] sck_sq, ss_sq, sdi_sq;
    logic       sck_pq;
    logic [6:0] shreg_q;
    logic [2:0] bit_cnt_q;
    logic       byte_vld_q;
    logic [7:0] byte_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sq     <= '0;
            ss_sq      <= '1;
            sdi_sq     <= '0;
            sck_pq     <= 1'b0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
        end else begin
            sck_sq     <= {sck_sq[0], sck};
            ss_sq      <= {ss_sq[0], ss};
            sdi_sq     <= {sdi_sq[0], sdi};
            sck_pq     <= sck_sq[1];
            byte_vld_q <= 1'b0;
            if (ss_sq[1]) begin
                bit_cnt_q <= '0;
            end else if (sck_sq[1] && !sck_pq) begin
                shreg_q   <= {shreg_q[5:0], sdi_sq[1]};
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (bit_cnt_q == 3'd7) begin
                    byte_vld_q <= 1'b1;
                    byte_q     <= {shreg_q, sdi_sq[1]};
                end
            end
        end
    end

    // ---------------- command decode / word assembler ----------------
    logic [7:0]    cmd_q, cmd_d;
    logic          first_q, first_d;
    logic [4:0]    index_q, index_d;
    logic [AW-1:0] ptr_q, ptr_d, size_q, size_d, base_sel;
    logic          ovf_q, ovf_d, dl_q, dl_d, end_q, end_d, part_q, part_d;
    logic [DW-1:0] asm_q, asm_d, asm_ins;
    logic [LBW-1:0] lane;
    logic          push;
    logic [AW-1:0] push_a;
    logic [DW-1:0] push_w;

    // FIFO / write-port state used by the decoder
    logic [AW-1:0] fa_q [FIFO_DEPTH];
    logic [DW-1:0] fd_q [FIFO_DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic [0:0]    st_q, st_d;
    logic          pop, push_ok;

    assign lane = ptr_q[LBW-1:0] & LANE_TOP;

    always_comb begin
        case (index_q)
            5'd0:    base_sel = BASE0;
            5'd1:    base_sel = BASE1;
            default: base_sel = BASE_DEF;
        endcase
    end

    always_comb begin
        asm_ins = asm_q;
        for (int unsigned l = 0; l < NL; l++) begin
            if (lane == LBW'(l)) asm_ins[l*8 +: 8] = byte_q;
        end
    end

    always_comb begin
        cmd_d   = cmd_q;
        first_d = first_q;
        index_d = index_q;
        ptr_d   = ptr_q;
        size_d  = size_q;
        ovf_d   = ovf_q;
        dl_d    = dl_q;
        end_d   = end_q;
        asm_d   = asm_q;
        part_d  = part_q;
        push    = 1'b0;
        push_a  = ptr_q & ~LANE_MSK;
        push_w  = asm_ins;
        // drain complete: nothing queued, nothing in flight, no byte arriving
        if (end_q && cnt_q == '0 && st_q == ST_IDLE && !byte_vld_q) begin
            dl_d  = 1'b0;
            end_d = 1'b0;
        end
        if (byte_vld_q) begin
            if (first_q) begin
                cmd_d   = byte_q;
                first_d = 1'b0;
            end else begin
                case (cmd_q)
                    8'h55: index_d = byte_q[4:0];
                    8'h53: begin
                        if (byte_q[0]) begin
                            ptr_d  = base_sel;
                            size_d = '0;
                            ovf_d  = 1'b0;
                            dl_d   = 1'b1;
                            end_d  = 1'b0;
                            asm_d  = '0;
                            part_d = 1'b0;
                        end else begin
                            end_d = 1'b1;
                            if (part_q) begin
                                push   = 1'b1;
                                push_w = asm_q;
                                asm_d  = '0;
                                part_d = 1'b0;
                            end
                        end
                    end
                    8'h54: begin
                        ptr_d  = ptr_q + 1'b1;
                        size_d = size_q + 1'b1;
                        if (lane == LANE_TOP) begin
                            push   = 1'b1;
                            asm_d  = '0;
                            part_d = 1'b0;
                        end else begin
                            asm_d  = asm_ins;
                            part_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (ss_sq[1]) first_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q   <= '0;
            first_q <= 1'b1;
            index_q <= '0;
            ptr_q   <= '0;
            size_q  <= '0;
            ovf_q   <= 1'b0;
            dl_q    <= 1'b0;
            end_q   <= 1'b0;
            asm_q   <= '0;
            part_q  <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            first_q <= first_d;
            index_q <= index_d;
            ptr_q   <= ptr_d;
            size_q  <= size_d;
            ovf_q   <= ovf_d || (push && !push_ok);
            dl_q    <= dl_d;
            end_q   <= end_d;
            asm_q   <= asm_d;
            part_q  <= part_d;
        end
    end

    // ---------------- word FIFO and write port ----------------
    assign pop     = (st_q == ST_WRITE) && ack;
    // a pop on the same edge frees the slot, so a push into a full FIFO succeeds
    assign push_ok = push && ((cnt_q != FULL_CNT) || pop);
    assign cnt_d   = cnt_q + (PW + 1)'(push_ok) - (PW + 1)'(pop);

    always_comb begin
        st_d = st_q;
        if (st_q == ST_IDLE) begin
            if (cnt_q != '0) st_d = ST_WRITE;
        end else if (ack) begin
            // stay in WRITE while words remain so acks can be back to back
            st_d = (cnt_d != '0) ? ST_WRITE : ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fa_q[i] <= '0;
                fd_q[i] <= '0;
            end
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            st_q  <= ST_IDLE;
        end else begin
            if (push_ok) begin
                fa_q[wp_q] <= push_a;
                fd_q[wp_q] <= push_w;
                wp_q       <= wp_q + 1'b1;
            end
            if (pop) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_d;
            st_q  <= st_d;
        end
    end

`ifdef DATA_IO_CRC_EN
    logic [15:0] crc_q;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= 16'hFFFF;
        end else if (byte_vld_q && !first_q) begin
            if (cmd_q == 8'h53 && byte_q[0]) crc_q <= 16'hFFFF;
            else if (cmd_q == 8'h54)         crc_q <= crc_step(crc_q, byte_q);
        end
    end

    assign crc = crc_q;
`else
    assign crc = 16'h0000;
`endif

    assign downloading = dl_q;
    assign index       = index_q;
    assign wr          = (st_q == ST_WRITE);
    assign a           = fa_q[rp_q];
    assign d           = fd_q[rp_q];
    assign size        = size_q;
    assign overflow    = ovf_q;

endmodule

// File: doc/spi_file_loader.md
# spi_file_loader

Parametrised successor to the SPI download path from the I/O controller. Receives OSD file-transfer commands (0x53 start/end, 0x54 data, 0x55 index) over the MiST SPI link and assembles payload bytes into DW-wide words. Buffers the words in a small FIFO and writes them to external RAM over a wr/ack handshake, so the RAM may stall. Runs entirely in the system clock domain: the SPI pins are oversampled, and no logic is clocked by sck.

## Interface
Parameters:
- DW, 16: RAM data width; 8, 16 or 32.
- AW, 25: RAM byte-address width.
- FIFO_DEPTH, 4: word FIFO depth; power of two, ≥2.
- BASE0, 25'h0E0000: load base for index 0.
- BASE1, 25'h100000: load base for index 1.
- BASE_DEF, 25'h120000: load base for every other index.

Ports:
- clk  in  1  system clock; must be ≥4× the sck rate.
- reset_n  in  1  asynchronous, active-low reset.
- sck, ss, sdi  in  1 each  SPI from the I/O controller; asynchronous to clk; mode 0, MSB first.
- downloading  out  1  high from the start command until the FIFO is drained after the end command.
- index  out  5  last file index received.
- wr  out  1  write request; held until ack.
- ack  in  1  RAM accepted the word on this clk edge.
- a  out  AW  word-aligned byte address; low log2(DW/8) bits are 0.
- d  out  DW  write data; byte 0 of the word sits in bits [7:0] (little-endian).
- size  out  AW  payload byte count of the current or last transfer.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- crc  out  16  payload CRC (see Configuration).

## Operation
- SPI front end:
  - sck, ss and sdi each pass through a 2-FF synchroniser.
  - A rising edge of the synchronised sck samples sdi.
  - Synchronised ss high clears the bit counter and the byte phase.
- Framing:
  - The first byte after ss falls is cmd.
  - Every following byte is a parameter byte of cmd.
- 0x55: index <= byte[4:0].
- 0x53 with byte[0]=1 (start):
  - byte pointer <= base selected by the current index.
  - size <= 0; overflow <= 0; CRC <= 16'hFFFF; downloading <= 1.
- 0x54: each byte goes into the word assembler at lane ptr[log2(DW/8)-1:0]; ptr and size then increment.
  - A word is pushed when the top lane fills. Pushed word address = ptr with its lane bits cleared.
  - ptr wraps modulo 2^AW.
- 0x53 with byte[0]=0 (end): a partially filled word is pushed, with unfilled lanes 0.
  - Once the FIFO is empty and no write is in flight, downloading <= 0.
- Push when the FIFO is full: the word is dropped and overflow <= 1. Bytes still count in size and CRC.
- Write port FSM:
  - IDLE→WRITE when the FIFO is not empty. a/d present the head entry and wr=1.
  - WRITE→IDLE on ack: pop.
  - a and d are stable while wr=1.
- A new start during a download re-bases the pointer. Words already queued are still written.

## Timing
- Reset values: downloading 0, index 0, wr 0, a 0, d 0, size 0, overflow 0, crc 16'hFFFF, FIFO empty, FSM IDLE.
- Latency from the sck edge of a byte's last bit:
  - 2 clk synchroniser, plus 1 clk edge detect, plus 1 clk push.
  - wr rises on the following clk when the FIFO was empty.
- Back-to-back writes: wr may stay high across consecutive acks. Throughput is 1 word per clk while ack is held high.
- Simultaneous push and pop with a full FIFO: the pop takes effect first, so the push succeeds.
- Reset asserted mid-transfer: all state clears immediately. FIFO contents are discarded and wr drops asynchronously.

## Configuration
- DATA_IO_CRC_EN defined:
  - crc is a running CRC-16/CCITT over 0x54 payload bytes: poly 0x1021, init 16'hFFFF, MSB first, no final XOR.
  - Updated one clk after each byte completes.
- DATA_IO_CRC_EN undefined: crc is tied to 16'h0000 and no CRC logic is built.

## Test plan
- DW=16, index 0, start, payload 11 22 33 44, end, ack always 1 -> writes (0x0E0000, 16'h2211), (0x0E0002, 16'h4433); size=4; downloading falls after the last ack.
- DW=32, index 1, 5 payload bytes AA BB CC DD EE, end -> writes (0x100000, 32'hDDCCBBAA), (0x100004, 32'h000000EE).
- 0x55 with 0x07, then start, 1 byte -> index=7; write to 0x120000.
- ack held low while 2×FIFO_DEPTH words are sent -> exactly FIFO_DEPTH words written once ack is released; overflow=1; size equals the full byte count.
- CRC_EN, payload ASCII "123456789" -> crc=16'h29B1.
- reset_n pulsed low after 3 payload bytes -> wr=0, downloading=0, size=0 the same cycle; the next clean start/download behaves normally.
